bcd_down_cnt: RTL and testbench
===============================

// Module: bcd_down_cnt
// PURPOSE
//  Synchronous multi-digit BCD down-counter (countdown timer): complement of the BCD up-counter.
//  Loads a preset, decrements once per enabled clock, and flags terminal zero.
//  Borrows ripple digit-to-digit.
//  Feeds display drivers and timeout logic downstream.
// PARAMETERS
//  DIGITS  2  number of BCD digits; Q width = 4*DIGITS; legal 1..4
//  WRAP    0  0: stop at zero and hold; 1: wrap from all-zero to all-nines and keep counting
// PORTS
//  CK        in   1         clock; all state changes on rising edge
//  nClear    in   1         asynchronous active-low reset
//  load      in   1         synchronous load of load_val; also starts counting
//  load_val  in   4*DIGITS  preset, BCD, digit 0 in bits [3:0]
//  en        in   1         count enable; one decrement per CK edge while high and running
//  Q         out  4*DIGITS  current count, BCD
//  running   out  1         counter active (loaded and not stopped at zero)
//  zero      out  1         Q == 0, combinational from Q
//  borrow    out  1         one-cycle pulse on the edge where Q goes 0 -> all-nines (WRAP=1 only)
//  done      out  1         one-cycle pulse on the edge where Q reaches 0 while running
// BEHAVIOUR
//  Reset (nClear=0, async, independent of CK):
//   - Q=0, running=0, borrow=0, done=0, zero=1.
//   - Held while nClear=0; first count edge is the first CK rise after nClear deasserts.
//  States: IDLE (running=0) and RUN (running=1).
//   - IDLE -> RUN on load.
//   - RUN -> IDLE when Q reaches 0 and WRAP=0.
//   - With WRAP=1, RUN is left only by reset.
//  Load:
//   - On CK edge with load=1: Q <= sanitised load_val; running <= 1.
//   - Sanitise: any digit > 9 is forced to 9.
//   - load has priority over en on the same edge; no decrement that cycle.
//   - load during RUN restarts from the new value.
//   - load_val == 0 with WRAP=0: Q=0, running stays 0, done not pulsed.
//  Decrement (running=1, en=1, load=0):
//   - Digit 0 decrements.
//   - A digit at 0 becomes 9 and borrows from the next digit.
//   - Borrow propagates within the same cycle; latency from edge to Q is one clock.
//   - en=0 holds Q; no pulses.
//  Terminal:
//   - Edge on which Q becomes 0: done=1 for exactly that cycle.
//   - WRAP=0: running<=0 on that same edge; Q holds 0 until next load; en ignored in IDLE.
//   - WRAP=1: next enabled edge sets Q = all nines and pulses borrow=1 for one cycle; running stays 1.
//  Outputs:
//   - Q, running, borrow and done are registered.
//   - zero is combinational from Q.
//   - Q never holds a non-BCD digit.
//  Reset mid-count: immediate Q=0, running=0, pulses cancelled.
// TESTING
//  1. Reset: nClear low mid-run, async (no CK) -> Q=00, running=0, zero=1, done=0 immediately.
//  2. Basic countdown, DIGITS=2, WRAP=0: load 12, en=1 -> Q 11,10,09,...,00;
//     done pulses on the 12th edge with Q=00; running=0; further edges hold 00.
//  3. Digit borrow: load 40, en=1 -> Q 39 after one edge;
//     en toggled 1,0,1 -> 39, 39, 38 (hold verified).
//  4. Wrap, WRAP=1: load 01, en=1 -> 00 (done=1), then 99 (borrow=1, one cycle), then 98; running stays 1.
//  5. Load priority/sanitise: load=1 with en=1 and load_val=8'hA5 -> Q=95, no decrement that edge;
//     load 07 during run -> Q=07.
//  6. Zero preload, WRAP=0: load 00 -> running=0, done=0, zero=1; en pulses leave Q=00.

Source files
------------

// File: rtl/bcd_down_cnt.sv
// Multi-digit BCD countdown timer with preset load, terminal-zero detection
// and optional wrap from all-zero to all-nines.
module bcd_down_cnt #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  CK,
  input  logic                  nClear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  running,
  output logic                  zero,
  output logic                  borrow,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   q_nx;
  logic [W-1:0]   san;
  logic [W-1:0]   dec;
  logic [W-1:0]   nines;
  logic           borrow_nx;
  logic           done_nx;

  // Per-digit datapath: sanitised preset, rippled decrement and the wrap value.
  always_comb begin
    logic bw;
    san   = '0;
    dec   = '0;
    nines = '0;
    bw    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      san[4*i +: 4]   = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      nines[4*i +: 4] = 4'd9;
      if (bw) begin
        if (Q[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
        end else begin
          dec[4*i +: 4] = Q[4*i +: 4] - 4'd1;
          bw            = 1'b0;
        end
      end else begin
        dec[4*i +: 4] = Q[4*i +: 4];
      end
    end
  end

  assign zero    = (Q == '0);
  assign running = (state == RUN);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    q_nx      = Q;
    borrow_nx = 1'b0;
    done_nx   = 1'b0;
    if (load) begin
      q_nx     = san;
      state_nx = (san == '0 && !WRAP) ? IDLE : RUN;
    end else if (state == RUN && en) begin
      if (zero) begin
        // Only reachable with WRAP=1: a counter that stops at zero is already IDLE.
        q_nx      = nines;
        borrow_nx = 1'b1;
      end else begin
        q_nx = dec;
        if (dec == '0) begin
          done_nx = 1'b1;
          if (!WRAP) state_nx = IDLE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CK or negedge nClear) begin
    if (!nClear) begin
      state  <= IDLE;
      Q      <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      Q      <= q_nx;
      borrow <= borrow_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_bcd_down_cnt.sv
// Self-checking bench: a stop-at-zero and a wrapping counter share stimulus and
// are compared against an integer-arithmetic reference model.
module tb_bcd_down_cnt;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 99;

  logic         CK = 1'b0;
  logic         nClear;
  logic         load;
  logic         en;
  logic [W-1:0] load_val;

  logic [W-1:0] q0, q1;
  logic         run0, run1, z0, z1, b0, b1, d0, d1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model, index 0 = WRAP=0, index 1 = WRAP=1.
  int mv    [2];
  bit mrun  [2];
  bit mdone [2];
  bit mbrw  [2];

  always #5 CK = ~CK;

  bcd_down_cnt #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_stop (
    .CK(CK), .nClear(nClear), .load(load), .load_val(load_val), .en(en),
    .Q(q0), .running(run0), .zero(z0), .borrow(b0), .done(d0)
  );

  bcd_down_cnt #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_wrap (
    .CK(CK), .nClear(nClear), .load(load), .load_val(load_val), .en(en),
    .Q(q1), .running(run1), .zero(z1), .borrow(b1), .done(d1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sanitise(input logic [W-1:0] v);
    int r     = 0;
    int scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r     += d * scale;
      scale *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int           x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      mv[w] = 0; mrun[w] = 1'b0; mdone[w] = 1'b0; mbrw[w] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int w = 0; w < 2; w++) begin
      mdone[w] = 1'b0;
      mbrw[w]  = 1'b0;
      if (load) begin
        mv[w]   = sanitise(load_val);
        mrun[w] = (mv[w] != 0) || (w == 1);
      end else if (mrun[w] && en) begin
        if (mv[w] == 0) begin
          mv[w]   = MAXV;
          mbrw[w] = 1'b1;
        end else begin
          mv[w] = mv[w] - 1;
          if (mv[w] == 0) begin
            mdone[w] = 1'b1;
            if (w == 0) mrun[w] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s stop Q", tag),       32'(q0),   32'(to_bcd(mv[0])));
    check($sformatf("%s stop running", tag), 32'(run0), 32'(mrun[0]));
    check($sformatf("%s stop zero", tag),    32'(z0),   32'(mv[0] == 0));
    check($sformatf("%s stop done", tag),    32'(d0),   32'(mdone[0]));
    check($sformatf("%s stop borrow", tag),  32'(b0),   32'(mbrw[0]));
    check($sformatf("%s wrap Q", tag),       32'(q1),   32'(to_bcd(mv[1])));
    check($sformatf("%s wrap running", tag), 32'(run1), 32'(mrun[1]));
    check($sformatf("%s wrap zero", tag),    32'(z1),   32'(mv[1] == 0));
    check($sformatf("%s wrap done", tag),    32'(d1),   32'(mdone[1]));
    check($sformatf("%s wrap borrow", tag),  32'(b1),   32'(mbrw[1]));
  endtask

  task automatic step(input logic l, input logic [W-1:0] lv, input logic e, input string tag);
    load     = l;
    load_val = lv;
    en       = e;
    @(posedge CK);
    #1;
    model_edge();
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    nClear = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    nClear = 1'b1;
  endtask

  initial begin
    nClear   = 1'b0;
    load     = 1'b0;
    en       = 1'b0;
    load_val = '0;
    model_reset();
    #3;
    check_all("por");
    #9;
    nClear = 1'b1;

    // Basic countdown from 12, then hold (stop) / wrap past zero.
    step(1'b1, 8'h12, 1'b1, "ld12");
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, $sformatf("cnt12_%0d", i));
    check("cnt12 end Q", 32'(q0), 32'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "post_zero");

    // Reset mid-run and reset cancelling a done pulse.
    step(1'b1, 8'h50, 1'b1, "ld50");
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "run50");
    async_reset("rst_mid");
    step(1'b1, 8'h01, 1'b0, "ld01a");
    step(1'b0, 8'h00, 1'b1, "done01");
    check("done before reset", 32'(d0), 32'h1);
    async_reset("rst_done");

    // Digit borrow and enable hold.
    step(1'b1, 8'h40, 1'b0, "ld40");
    step(1'b0, 8'h00, 1'b1, "b39");
    check("borrow 40->39", 32'(q0), 32'h39);
    step(1'b0, 8'h00, 1'b0, "hold39");
    step(1'b0, 8'h00, 1'b1, "b38");

    // Wrap sequence: 01 -> 00 (done) -> 99 (borrow) -> 98.
    step(1'b1, 8'h01, 1'b0, "ld01b");
    step(1'b0, 8'h00, 1'b1, "w00");
    step(1'b0, 8'h00, 1'b1, "w99");
    check("wrap to 99", 32'(q1), 32'h99);
    step(1'b0, 8'h00, 1'b1, "w98");

    // Load priority and sanitising, reload during run.
    step(1'b1, 8'hA5, 1'b1, "ldA5");
    check("sanitise A5", 32'(q0), 32'h95);
    step(1'b0, 8'h00, 1'b1, "d94");
    step(1'b1, 8'h07, 1'b1, "ld07");
    step(1'b1, 8'hFC, 1'b0, "ldFC");

    // Zero preload.
    step(1'b1, 8'h00, 1'b0, "ld00");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, "z_en1");
      step(1'b0, 8'h00, 1'b0, "z_en0");
    end

    // Randomised traffic, including non-BCD presets and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step($urandom_range(7) == 0, W'($urandom), $urandom_range(3) != 0,
             $sformatf("rnd%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
